// File: rtl/onchip_ram_pipelined.sv
// onchip_ram_pipelined: single-port on-chip RAM behind an Avalon-MM pipelined slave.
// Latency: READ_LATENCY (1 or 2) cycles from read acceptance to readdatavalid; writes commit at the accepting edge.
// Backpressure: waitrequest is high during the post-reset clear sweep and whenever clken=0 or reset_req=1.
//
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   address, byteenable, chipselect, read, write, writedata   Avalon-MM request side
//   readdata, readdatavalid, waitrequest                      Avalon-MM response side
//   clken, reset_req    stall controls; either one freezes the block
//   init_done           high once the clear sweep has finished
// Optional macro ONCHIP_RAM_PARITY_EN adds per-byte even parity and the ports
// parity_err (pulses with readdatavalid on a mismatch) and err_addr (sticky first failing address).
module onchip_ram_pipelined #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    input  logic                  clken,
    input  logic                  reset_req,
`ifdef ONCHIP_RAM_PARITY_EN
    output logic                  parity_err,
    output logic [ADDR_W-1:0]     err_addr,
`endif
    output logic                  init_done
);

    localparam int NB = DATA_W / 8;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                init_done_q;

    logic                stall;
    logic                clr_we;
    logic                accept;
    logic                wr_en;
    logic                rd_en;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Stage-1 (RAM output register) and final output stage.
    logic                rd_vld1_q;
    logic [DATA_W-1:0]   rd_dat1_q;
    logic                vld_out;
    logic [DATA_W-1:0]   dat_out;

    assign stall  = ~clken | reset_req;
    assign clr_we = (CLEAR_ON_RESET != 0) && (state_q == ST_CLEAR) && !stall;

    assign waitrequest = (state_q != ST_RUN) | stall;
    assign accept      = chipselect & (read | write) & ~waitrequest;
    // A simultaneous read+write performs only the write.
    assign wr_en       = accept & write;
    assign rd_en       = accept & read & ~write;

    // Control FSM: clear sweep, then run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
        end else if (state_q == ST_CLEAR) begin
            if (CLEAR_ON_RESET == 0) begin
                state_q     <= ST_RUN;
                init_done_q <= 1'b1;
            end else if (!stall) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
                // DEPTH is a power of two, so all-ones is the last word.
                if (&clr_cnt_q) begin
                    state_q     <= ST_RUN;
                    init_done_q <= 1'b1;
                end
            end
        end
    end

    assign init_done = init_done_q;

`ifdef ONCHIP_RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];

    function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] d);
        logic [NB-1:0] p;
        p = '0;
        for (int b = 0; b < NB; b++) p[b] = ^d[b*8 +: 8];
        return p;
    endfunction
`endif

    // Storage array: no reset, contents come from the clear sweep or writes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt_q] <= '0;
`ifdef ONCHIP_RAM_PARITY_EN
            par_mem[clr_cnt_q] <= '0;
`endif
        end else if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (byteenable[b]) begin
                    mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
                    par_mem[address][b] <= ^writedata[b*8 +: 8];
`endif
                end
            end
        end
    end

`ifdef ONCHIP_RAM_PARITY_EN
    logic              rd_perr1_q;
    logic [ADDR_W-1:0] rd_addr1_q;
    logic              perr_out;
    logic [ADDR_W-1:0] addr_out;
    logic              err_seen_q;
    logic [ADDR_W-1:0] err_addr_q;
`endif

    // Stage 1: registered RAM read; holds while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld1_q <= 1'b0;
            rd_dat1_q <= '0;
`ifdef ONCHIP_RAM_PARITY_EN
            rd_perr1_q <= 1'b0;
            rd_addr1_q <= '0;
`endif
        end else if (!stall) begin
            rd_vld1_q <= rd_en;
            if (rd_en) begin
                rd_dat1_q <= mem[address];
`ifdef ONCHIP_RAM_PARITY_EN
                rd_perr1_q <= |(byte_par(mem[address]) ^ par_mem[address]);
                rd_addr1_q <= address;
`endif
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              rd_vld2_q;
            logic [DATA_W-1:0] rd_dat2_q;
`ifdef ONCHIP_RAM_PARITY_EN
            logic              rd_perr2_q;
            logic [ADDR_W-1:0] rd_addr2_q;
`endif
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd_vld2_q <= 1'b0;
                    rd_dat2_q <= '0;
`ifdef ONCHIP_RAM_PARITY_EN
                    rd_perr2_q <= 1'b0;
                    rd_addr2_q <= '0;
`endif
                end else if (!stall) begin
                    rd_vld2_q <= rd_vld1_q;
                    rd_dat2_q <= rd_dat1_q;
`ifdef ONCHIP_RAM_PARITY_EN
                    rd_perr2_q <= rd_perr1_q;
                    rd_addr2_q <= rd_addr1_q;
`endif
                end
            end
            assign vld_out = rd_vld2_q;
            assign dat_out = rd_dat2_q;
`ifdef ONCHIP_RAM_PARITY_EN
            assign perr_out = rd_perr2_q;
            assign addr_out = rd_addr2_q;
`endif
        end else begin : g_lat1
            assign vld_out = rd_vld1_q;
            assign dat_out = rd_dat1_q;
`ifdef ONCHIP_RAM_PARITY_EN
            assign perr_out = rd_perr1_q;
            assign addr_out = rd_addr1_q;
`endif
        end
    endgenerate

    // A held output stage is masked while stalled so each read produces
    // exactly one readdatavalid pulse, on the first unstalled cycle.
    assign readdatavalid = vld_out & ~stall;
    assign readdata      = dat_out;

`ifdef ONCHIP_RAM_PARITY_EN
    assign parity_err = perr_out & readdatavalid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_seen_q <= 1'b0;
            err_addr_q <= '0;
        end else if (parity_err && !err_seen_q) begin
            err_seen_q <= 1'b1;
            err_addr_q <= addr_out;
        end
    end

    assign err_addr = err_addr_q;
`endif

endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// Bench for onchip_ram_pipelined: two instances (READ_LATENCY 1 and 2, DEPTH 16)
// share one stimulus stream; expected read responses are queued per instance
// with the cycle they are due and checked by an independent monitor.
module tb_onchip_ram_pipelined;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        clken;
    logic        reset_req;

    logic [31:0] rd1, rd2;
    logic        rdv1, rdv2, wait1, wait2, done1, done2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [31:0] d;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    onchip_ram_pipelined #(.DATA_W(32), .DEPTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_lat1 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .readdata(rd1), .readdatavalid(rdv1), .waitrequest(wait1),
        .clken(clken), .reset_req(reset_req), .init_done(done1)
    );

    onchip_ram_pipelined #(.DATA_W(32), .DEPTH(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_lat2 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .readdata(rd2), .readdatavalid(rdv2), .waitrequest(wait2),
        .clken(clken), .reset_req(reset_req), .init_done(done2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: samples just after each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rdv1) begin
                if (q1.size() == 0) chk("lat1 unexpected readdatavalid", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("lat1 readdata", rd1, e.d);
                    chk("lat1 valid cycle", cyc, e.due);
                end
            end
            if (rdv2) begin
                if (q2.size() == 0) chk("lat2 unexpected readdatavalid", 32'd1, 32'd0);
                else begin
                    e = q2.pop_front();
                    chk("lat2 readdata", rd2, e.d);
                    chk("lat2 valid cycle", cyc, e.due);
                end
            end
        end
    end

    // All bus tasks start right after a falling edge and end on the next one.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        address = a; writedata = d; byteenable = be;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; byteenable = 4'hF;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] d, input int extra);
        exp_t e;
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
        e.d = d;
        e.due = cyc + 1 + extra; q1.push_back(e);
        e.due = cyc + 2 + extra; q2.push_back(e);
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
    endtask

    // Counts the cycles from reset release until init_done (bounded).
    task automatic wait_init(input string nm);
        int   n;
        logic allw;
        n = 0; allw = 1'b1;
        #1;
        while (!done1 && n < 200) begin
            if (!wait1 || !wait2) allw = 1'b0;
            n++;
            @(negedge clk);
            #1;
        end
        chk({nm, " clear cycles"}, n, 32'd16);
        chk({nm, " waitrequest during clear"}, {31'd0, allw}, 32'd1);
        chk({nm, " lat2 init_done"}, {31'd0, done2}, 32'd1);
        chk({nm, " waitrequest in run"}, {30'd0, wait1, wait2}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; address = '0; byteenable = 4'hF; chipselect = 1'b0;
        read = 1'b0; write = 1'b0; writedata = '0; clken = 1'b1; reset_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset lat1 readdata", rd1, 32'd0);
        chk("reset lat2 readdata", rd2, 32'd0);
        chk("reset readdatavalid", {30'd0, rdv1, rdv2}, 32'd0);
        chk("reset waitrequest", {30'd0, wait1, wait2}, 32'd3);
        chk("reset init_done", {30'd0, done1, done2}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_init("initial");

        // Whole array reads back as zero, issued back to back.
        @(negedge clk);
        for (int i = 0; i < 16; i++) do_read(4'(i), 32'h0, 0);

        // Byte-enable merge, then read on the very next cycle.
        do_write(4'd3, 32'hAABBCCDD, 4'hF);
        do_write(4'd3, 32'h11223344, 4'h5);
        do_read(4'd3, 32'hAA22CC44, 0);

        // Pipelined back-to-back reads.
        do_write(4'd0, 32'h10, 4'hF);
        do_write(4'd1, 32'h20, 4'hF);
        do_write(4'd2, 32'h30, 4'hF);
        do_write(4'd3, 32'h40, 4'hF);
        for (int i = 0; i < 4; i++) do_read(4'(i), 32'h10 * (i + 1), 0);

        // read+write together: write happens, no response.
        chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 4'd6;
        writedata = 32'h66; byteenable = 4'hF;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        do_read(4'd6, 32'h66, 0);

        // chipselect low: ignored.
        chipselect = 1'b0; write = 1'b1; read = 1'b1; address = 4'd6; writedata = 32'hDEAD;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        // byteenable=0: accepted, changes nothing.
        do_write(4'd6, 32'hBEEF, 4'h0);
        do_read(4'd6, 32'h66, 0);

        // reset_req stalls the bus; a request presented now is not accepted.
        repeat (3) @(negedge clk);
        reset_req = 1'b1; chipselect = 1'b1; read = 1'b1; address = 4'd6;
        #1;
        chk("reset_req waitrequest", {30'd0, wait1, wait2}, 32'd3);
        @(negedge clk);
        reset_req = 1'b0; chipselect = 1'b0; read = 1'b0;
        #1;
        chk("after reset_req waitrequest", {30'd0, wait1, wait2}, 32'd0);
        @(negedge clk);

        // clken=0 for 3 cycles right after a read: response slips exactly 3 cycles.
        do_write(4'd7, 32'h77, 4'hF);
        do_read(4'd7, 32'h77, 3);
        clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall waitrequest", {30'd0, wait1, wait2}, 32'd3);
            @(negedge clk);
        end
        clken = 1'b1;
        repeat (4) @(negedge clk);
        chk("lat1 queue drained before reset", q1.size(), 32'd0);
        chk("lat2 queue drained before reset", q2.size(), 32'd0);

        // Reset in the cycle after a read is accepted: the response is dropped.
        chipselect = 1'b1; read = 1'b1; address = 4'd3;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0; reset_n = 1'b0;
        #1;
        chk("midreset readdatavalid", {30'd0, rdv1, rdv2}, 32'd0);
        chk("midreset init_done", {30'd0, done1, done2}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_init("after reset");

        // Sweep restarted and cleared previously written words.
        @(negedge clk);
        do_read(4'd3, 32'h0, 0);
        do_read(4'd0, 32'h0, 0);
        do_read(4'd7, 32'h0, 0);
        do_read(4'd15, 32'h0, 0);

        repeat (6) @(negedge clk);
        chk("lat1 queue empty at end", q1.size(), 32'd0);
        chk("lat2 queue empty at end", q2.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
